// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter
//
// Merges the core's instruction bus (read-only) and data bus (read/write) onto
// a single Wishbone-style master port. Round-robin arbitration between the two
// requesters; a grant is held until the memory acks or the requester drops cyc.
// Every grant is followed by one idle cycle before the next arbitration.
//
// Optional feature (macro ARB_TIMEOUT_EN): a bus watchdog that sets the sticky
// o_timeout flag once a granted transfer has waited TIMEOUT cycles for an ack.
// Without the macro o_timeout is tied low.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   i_ibus_* / o_ibus_*        instruction fetch requester (adr, cyc / rdt, ack)
//   i_dbus_* / o_dbus_*        data requester (adr, dat, sel, we, cyc / rdt, ack)
//   o_wb_* / i_wb_*            shared memory master port
//   o_timeout                  sticky watchdog flag
module serv_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   // Instruction bus
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   // Data bus
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   // Memory port
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   // Watchdog
   output logic        o_timeout
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   logic [1:0] state_q, state_d;
   // Last granted port: 0 = ibus, 1 = dbus. Resets to 1 so ibus wins the first tie.
   logic       rr_last_q, rr_last_d;
   logic       wb_cyc;

   // ---------------------------------------------------------------------------
   // Arbitration FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      case (state_q)
         IDLE: begin
            // On a tie the port opposite the last grant wins.
            if (i_ibus_cyc && (!i_dbus_cyc || rr_last_q)) begin
               state_d   = GNT_I;
               rr_last_d = 1'b0;
            end else if (i_dbus_cyc) begin
               state_d   = GNT_D;
               rr_last_d = 1'b1;
            end
         end
         // Ack completes the transfer; dropping cyc without an ack aborts it.
         GNT_I: if (!i_ibus_cyc || i_wb_ack) state_d = IDLE;
         GNT_D: if (!i_dbus_cyc || i_wb_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output mux. cyc is gated by the requester's own cyc so an abort drops the
   // memory request in the same cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      wb_cyc     = 1'b0;
      o_wb_adr   = 32'h0;
      o_wb_dat   = 32'h0;
      o_wb_sel   = 4'h0;
      o_wb_we    = 1'b0;
      o_ibus_ack = 1'b0;
      o_ibus_rdt = 32'h0;
      o_dbus_ack = 1'b0;
      o_dbus_rdt = 32'h0;
      case (state_q)
         GNT_I: begin
            wb_cyc     = i_ibus_cyc;
            o_wb_adr   = i_ibus_adr;
            o_wb_sel   = 4'hF;
            o_ibus_ack = i_wb_ack & i_ibus_cyc;
            o_ibus_rdt = i_wb_rdt;
         end
         GNT_D: begin
            wb_cyc     = i_dbus_cyc;
            o_wb_adr   = i_dbus_adr;
            o_wb_dat   = i_dbus_dat;
            o_wb_sel   = i_dbus_sel;
            o_wb_we    = i_dbus_we;
            o_dbus_ack = i_wb_ack & i_dbus_cyc;
            o_dbus_rdt = i_wb_rdt;
         end
         default: ;
      endcase
   end

   assign o_wb_cyc = wb_cyc;

   // ---------------------------------------------------------------------------
   // Bus watchdog
   // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
   logic            waiting;

   assign waiting = (state_q != IDLE) && wb_cyc && !i_wb_ack;

   always_comb begin
      cnt_d = '0;
      if (waiting) begin
         // Saturate so the count never wraps back below the limit.
         cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      end
      timeout_d = timeout_q | (cnt_d == CntMax);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   localparam logic [7:0] TimeoutByte = 8'(TIMEOUT);
   logic unused_timeout;
   assign unused_timeout = ^TimeoutByte;
   assign o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Self-checking bench for serv_bus_arbiter. Expected grants are queued when a
// request is driven and popped when the memory port shows the transfer.
module tb_serv_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] i_ibus_adr;
   logic        i_ibus_cyc;
   logic [31:0] o_ibus_rdt;
   logic        o_ibus_ack;
   logic [31:0] i_dbus_adr;
   logic [31:0] i_dbus_dat;
   logic [3:0]  i_dbus_sel;
   logic        i_dbus_we;
   logic        i_dbus_cyc;
   logic [31:0] o_dbus_rdt;
   logic        o_dbus_ack;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic [31:0] i_wb_rdt;
   logic        i_wb_ack;
   logic        o_timeout;

   always #5 clock = ~clock;

   serv_bus_arbiter #(
      .TIMEOUT(15)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .i_ibus_adr (i_ibus_adr),
      .i_ibus_cyc (i_ibus_cyc),
      .o_ibus_rdt (o_ibus_rdt),
      .o_ibus_ack (o_ibus_ack),
      .i_dbus_adr (i_dbus_adr),
      .i_dbus_dat (i_dbus_dat),
      .i_dbus_sel (i_dbus_sel),
      .i_dbus_we  (i_dbus_we),
      .i_dbus_cyc (i_dbus_cyc),
      .o_dbus_rdt (o_dbus_rdt),
      .o_dbus_ack (o_dbus_ack),
      .o_wb_adr   (o_wb_adr),
      .o_wb_dat   (o_wb_dat),
      .o_wb_sel   (o_wb_sel),
      .o_wb_we    (o_wb_we),
      .o_wb_cyc   (o_wb_cyc),
      .i_wb_rdt   (i_wb_rdt),
      .i_wb_ack   (i_wb_ack),
      .o_timeout  (o_timeout)
   );

   typedef struct {
      bit          port;  // 0 = ibus, 1 = dbus
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

`ifdef ARB_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next active edge; inputs are driven from here.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_i(input logic [31:0] adr);
      exp_t e;
      e.port = 1'b0; e.adr = adr; e.dat = 32'h0; e.sel = 4'hF; e.we = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_d(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
      exp_t e;
      e.port = 1'b1; e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
      sb.push_back(e);
   endtask

   // Wait (bounded) for the next grant, compare it against the queue head,
   // ack it with rdt and check routing, then check the idle bubble.
   task automatic serve(input logic [31:0] rdt);
      exp_t e;
      int   n = 0;
      while (!o_wb_cyc && n < 8) begin
         tick();
         n++;
      end
      chk("grant_seen", o_wb_cyc, 1);
      e = sb.pop_front();
      chk("wb_adr", o_wb_adr, e.adr);
      chk("wb_dat", o_wb_dat, e.dat);
      chk("wb_sel", o_wb_sel, e.sel);
      chk("wb_we",  o_wb_we,  e.we);
      i_wb_ack = 1'b1;
      i_wb_rdt = rdt;
      #1;
      chk("ibus_ack", o_ibus_ack, e.port ? 0 : 1);
      chk("ibus_rdt", o_ibus_rdt, e.port ? 32'h0 : rdt);
      chk("dbus_ack", o_dbus_ack, e.port ? 1 : 0);
      chk("dbus_rdt", o_dbus_rdt, e.port ? rdt : 32'h0);
      tick();
      i_wb_ack = 1'b0;
      i_wb_rdt = 32'h0;
      #1;
      chk("bubble_cyc", o_wb_cyc, 0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cyc"},  o_wb_cyc,   0);
      chk({tag, "_adr"},  o_wb_adr,   0);
      chk({tag, "_dat"},  o_wb_dat,   0);
      chk({tag, "_sel"},  o_wb_sel,   0);
      chk({tag, "_we"},   o_wb_we,    0);
      chk({tag, "_iack"}, o_ibus_ack, 0);
      chk({tag, "_dack"}, o_dbus_ack, 0);
      chk({tag, "_tmo"},  o_timeout,  0);
   endtask

   initial begin
      reset      = 1'b1;
      i_ibus_adr = 32'h0;
      i_ibus_cyc = 1'b0;
      i_dbus_adr = 32'h0;
      i_dbus_dat = 32'h0;
      i_dbus_sel = 4'h0;
      i_dbus_we  = 1'b0;
      i_dbus_cyc = 1'b0;
      i_wb_rdt   = 32'h0;
      i_wb_ack   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk_idle_outputs("reset");

      // Single instruction fetch, one-cycle arbitration latency.
      i_ibus_cyc = 1'b1;
      i_ibus_adr = 32'h100;
      push_i(32'h100);
      #1;
      chk("ifetch_latency", o_wb_cyc, 0);
      tick();
      serve(32'h0000_0013);
      i_ibus_cyc = 1'b0;

      // Data write.
      i_dbus_cyc = 1'b1;
      i_dbus_adr = 32'h2000;
      i_dbus_dat = 32'hCAFE_F00D;
      i_dbus_sel = 4'b0011;
      i_dbus_we  = 1'b1;
      push_d(32'h2000, 32'hCAFE_F00D, 4'b0011, 1'b1);
      #1;
      chk("dwrite_latency", o_wb_cyc, 0);
      tick();
      serve(32'hDEAD_BEEF);
      i_dbus_cyc = 1'b0;
      i_dbus_we  = 1'b0;
      tick();
      chk("dwrite_idle", o_wb_cyc, 0);

      // Round robin with both ports requesting continuously: I, D, I.
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      i_ibus_cyc = 1'b1;
      i_ibus_adr = 32'h200;
      i_dbus_cyc = 1'b1;
      i_dbus_adr = 32'h3000;
      i_dbus_dat = 32'h0;
      i_dbus_sel = 4'hF;
      i_dbus_we  = 1'b0;
      push_i(32'h200);
      push_d(32'h3000, 32'h0, 4'hF, 1'b0);
      push_i(32'h200);
      tick();
      serve(32'h1111_1111);
      serve(32'h2222_2222);
      serve(32'h3333_3333);
      i_ibus_cyc = 1'b0;
      i_dbus_cyc = 1'b0;
      tick();

      // Abort: dbus drops cyc before any ack; then a spurious ack in IDLE.
      i_dbus_cyc = 1'b1;
      i_dbus_adr = 32'h4000;
      tick();
      chk("abort_granted", o_wb_cyc, 1);
      i_dbus_cyc = 1'b0;
      #1;
      chk("abort_cyc_drop", o_wb_cyc, 0);
      tick();
      i_wb_ack = 1'b1;
      i_wb_rdt = 32'h5555_AAAA;
      #1;
      chk("spurious_iack", o_ibus_ack, 0);
      chk("spurious_dack", o_dbus_ack, 0);
      chk("spurious_drdt", o_dbus_rdt, 0);
      tick();
      chk("spurious_cyc", o_wb_cyc, 0);
      i_wb_ack = 1'b0;
      i_wb_rdt = 32'h0;

      // Watchdog: ibus granted, ack withheld.
      i_ibus_cyc = 1'b1;
      i_ibus_adr = 32'h600;
      tick();
      chk("wd_granted", o_wb_cyc, 1);
      chk("wd_start", o_timeout, 0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("wd_wait%0d", k), o_timeout, (TimeoutEn && k >= 15) ? 1 : 0);
      end
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack   = 1'b0;
      i_ibus_cyc = 1'b0;
      #1;
      chk("wd_sticky", o_timeout, TimeoutEn ? 1 : 0);
      tick();
      chk("wd_sticky2", o_timeout, TimeoutEn ? 1 : 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("wd_reset_clr", o_timeout, 0);

      // Reset mid-transfer during a dbus grant, ibus held off meanwhile.
      i_dbus_cyc = 1'b1;
      i_dbus_adr = 32'h7000;
      i_dbus_we  = 1'b1;
      i_dbus_dat = 32'h0BAD_F00D;
      i_dbus_sel = 4'hF;
      tick();
      chk("mid_granted", o_wb_cyc, 1);
      i_ibus_cyc = 1'b1;
      i_ibus_adr = 32'h800;
      #1;
      chk("mid_holdoff_adr", o_wb_adr, 32'h7000);
      reset = 1'b1;
      tick();
      chk("mid_reset_cyc", o_wb_cyc, 0);
      reset     = 1'b0;
      i_dbus_we = 1'b0;
      push_i(32'h800);
      tick();
      serve(32'h9999_0000);
      i_ibus_cyc = 1'b0;
      i_dbus_cyc = 1'b0;
      tick();
      chk("final_idle", o_wb_cyc, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
